// File: rtl/reg_file_pkg.sv
// Shared definitions for the parametrised register file: operation encodings
// and the select-width helper.
package reg_file_pkg;

    typedef enum logic [1:0] {
        FS_CLR  = 2'b00,
        FS_LOAD = 2'b01,
        FS_DEC  = 2'b10,
        FS_INC  = 2'b11
    } funsel_e;

    // Ceiling log2, floored at 1 so a select port never collapses to zero width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r = r + 1;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/reg_cell.sv
// One register of the file plus its sticky overflow flag; applies the selected
// operation when enabled.
module reg_cell
    import reg_file_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned SAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   funsel,
    input  logic [W-1:0] load,
    input  logic         ovf_clr,
    output logic [W-1:0] q,
    output logic         ovf
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] q_next;
    logic         ovf_set;

    always_comb begin
        q_next  = q;
        ovf_set = 1'b0;
        case (funsel_e'(funsel))
            FS_CLR:  q_next = '0;
            FS_LOAD: q_next = load;
            FS_INC: begin
                if (q == MAX) begin
                    ovf_set = 1'b1;
                    q_next  = (SAT != 0) ? MAX : '0;
                end else begin
                    q_next = q + 1'b1;
                end
            end
            FS_DEC: begin
                if (q == '0) begin
                    ovf_set = 1'b1;
                    q_next  = (SAT != 0) ? '0 : MAX;
                end else begin
                    q_next = q - 1'b1;
                end
            end
            default: q_next = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            if (en) q <= q_next;
            // A set on the same edge as a clear takes priority.
            ovf <= (ovf & ~ovf_clr) | (en & ovf_set);
        end
    end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: NREG cells, two combinational read ports and an
// optional load-to-read bypass.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned NREG   = 8,
    parameter int unsigned SAT    = 0,
    parameter int unsigned BYPASS = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               funsel,
    input  logic [NREG-1:0]          regsel,
    input  logic [W-1:0]             load,
    input  logic [clog2(NREG)-1:0]   o1sel,
    input  logic [clog2(NREG)-1:0]   o2sel,
    input  logic                     ovf_clr,
    output logic [W-1:0]             o1,
    output logic [W-1:0]             o2,
    output logic [NREG-1:0]          ovf
);

    logic [W-1:0] regs [NREG];

    for (genvar i = 0; i < NREG; i++) begin : g_cell
        reg_cell #(
            .W   (W),
            .SAT (SAT)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .en      (regsel[i]),
            .funsel  (funsel),
            .load    (load),
            .ovf_clr (ovf_clr),
            .q       (regs[i]),
            .ovf     (ovf[i])
        );
    end

    logic is_load;
    assign is_load = (funsel == FS_LOAD);

    // Only loads are forwarded; arithmetic results appear after the edge.
    always_comb begin
        o1 = regs[o1sel];
        o2 = regs[o2sel];
        if (BYPASS != 0) begin
            if (is_load && regsel[o1sel]) o1 = load;
            if (is_load && regsel[o2sel]) o2 = load;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench: two instances (wrap/no bypass and saturate/bypass) share
// stimulus and are checked against an abstract model of the register file.
module tb_reg_file_param;
    import reg_file_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] funsel = 2'b00;
    logic [7:0] regsel = 8'h00;
    logic [7:0] load = 8'h00;
    logic [2:0] o1sel = 3'd0;
    logic [2:0] o2sel = 3'd0;
    logic       ovf_clr = 1'b0;

    logic [7:0] o1_a, o2_a, ovf_a;
    logic [7:0] o1_b, o2_b, ovf_b;

    always #5 clk = ~clk;

    reg_file_param #(.W(8), .NREG(8), .SAT(0), .BYPASS(0)) dut_a (
        .clk(clk), .rst(rst), .funsel(funsel), .regsel(regsel), .load(load),
        .o1sel(o1sel), .o2sel(o2sel), .ovf_clr(ovf_clr),
        .o1(o1_a), .o2(o2_a), .ovf(ovf_a)
    );

    reg_file_param #(.W(8), .NREG(8), .SAT(1), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .funsel(funsel), .regsel(regsel), .load(load),
        .o1sel(o1sel), .o2sel(o2sel), .ovf_clr(ovf_clr),
        .o1(o1_b), .o2(o2_b), .ovf(ovf_b)
    );

    typedef struct {
        int unsigned o1a, o2a, ovfa, o1b, o2b, ovfb;
    } exp_t;

    exp_t        sb[$];
    int unsigned ma[8], mb[8];
    int unsigned fa, fb;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One register operation in plain integer arithmetic.
    function automatic int unsigned step(input int unsigned v, input int unsigned fs,
                                         input int unsigned ld, input bit sat,
                                         output bit of);
        of = 1'b0;
        case (fs)
            0: return 0;
            1: return ld;
            3: if (v == 255) begin of = 1'b1; return sat ? 255 : 0; end
               else return v + 1;
            default: if (v == 0) begin of = 1'b1; return sat ? 0 : 255; end
               else return v - 1;
        endcase
    endfunction

    task automatic drive(input bit r, input int unsigned fs, input int unsigned rs,
                         input int unsigned ld, input int unsigned s1, input int unsigned s2,
                         input bit clr);
        exp_t e;
        int unsigned seta, setb;
        bit of;
        bit ldop;
        @(posedge clk);
        #1;
        rst = r; funsel = fs[1:0]; regsel = rs[7:0]; load = ld[7:0];
        o1sel = s1[2:0]; o2sel = s2[2:0]; ovf_clr = clr;
        ldop = (fs == 1);
        e.o1a = ma[s1]; e.o2a = ma[s2]; e.ovfa = fa;
        e.o1b = (ldop && rs[s1]) ? ld : mb[s1];
        e.o2b = (ldop && rs[s2]) ? ld : mb[s2];
        e.ovfb = fb;
        sb.push_back(e);
        seta = 0; setb = 0;
        for (int i = 0; i < 8; i++) begin
            if (r) begin
                ma[i] = 0; mb[i] = 0;
            end else if (rs[i]) begin
                ma[i] = step(ma[i], fs, ld, 1'b0, of); if (of) seta |= (1 << i);
                mb[i] = step(mb[i], fs, ld, 1'b1, of); if (of) setb |= (1 << i);
            end
        end
        fa = r ? 0 : ((clr ? 0 : fa) | seta);
        fb = r ? 0 : ((clr ? 0 : fb) | setb);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("o1_wrap",   o1_a,  e.o1a);
            chk("o2_wrap",   o2_a,  e.o2a);
            chk("ovf_wrap",  ovf_a, e.ovfa);
            chk("o1_sat",    o1_b,  e.o1b);
            chk("o2_sat",    o2_b,  e.o2b);
            chk("ovf_sat",   ovf_b, e.ovfb);
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin ma[i] = 0; mb[i] = 0; end
        fa = 0; fb = 0;

        // Reset after activity, then read every index
        drive(0, 1, 8'hFF, 8'hA5, 0, 1, 0);
        drive(0, 3, 8'hFF, 8'h00, 2, 3, 0);
        drive(1, 3, 8'hFF, 8'h00, 4, 5, 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 8'h77, i, 7 - i, 0);

        // Multi-register load, untouched neighbour
        drive(0, 1, 8'h05, 8'h95, 0, 2, 0);
        drive(0, 1, 8'h00, 8'h00, 0, 2, 0);
        drive(0, 1, 8'h00, 8'h00, 1, 1, 0);

        // Wrap/saturate at the top and bottom
        drive(0, 1, 8'h08, 8'hFF, 3, 3, 0);
        drive(0, 3, 8'h08, 8'h00, 3, 3, 0);
        drive(0, 2, 8'h08, 8'h00, 3, 3, 0);
        drive(0, 1, 8'h10, 8'h00, 4, 4, 0);
        drive(0, 2, 8'h10, 8'h00, 4, 4, 0);
        drive(0, 1, 8'h10, 8'hFF, 4, 4, 0);
        drive(0, 3, 8'h10, 8'h00, 4, 4, 0);
        drive(0, 0, 8'h00, 8'h00, 4, 3, 0);

        // Flag clear coinciding with a new overflow
        drive(0, 1, 8'h20, 8'hFF, 5, 5, 0);
        drive(0, 3, 8'h20, 8'h00, 5, 5, 1);
        drive(0, 0, 8'h00, 8'h00, 5, 5, 0);

        // Bypass of load, not of increment
        drive(0, 1, 8'h80, 8'h3C, 7, 6, 0);
        drive(0, 3, 8'h80, 8'h3C, 7, 7, 0);
        drive(0, 0, 8'h80, 8'h00, 7, 7, 0);
        drive(0, 0, 8'h00, 8'h00, 7, 7, 0);

        for (int n = 0; n < 600; n++) begin
            int unsigned ld, rs;
            case ($urandom_range(0, 3))
                0: ld = 0;
                1: ld = 255;
                default: ld = $urandom_range(0, 255);
            endcase
            rs = ($urandom_range(0, 2) == 0) ? (1 << $urandom_range(0, 7)) : $urandom_range(0, 255);
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 3), rs, ld,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7) == 0);
        end

        @(posedge clk);
        #1;
        regsel = 8'h00;
        @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised general-purpose register file; successor to the fixed 8x8 register bank.
- Width and register count are generic; adds a saturating/wrapping arithmetic mode, per-register sticky overflow flags and optional write-to-read bypass.
- Feeds the ALU A/B operand muxes in the system datapath; loaded from the ALU/memory bus.

Parameters:
- W, 8, register data width in bits (>=2).
- NREG, 8, number of registers (power of 2, >=2).
- SAT, 0, 0 = increment/decrement wrap modulo 2^W; 1 = saturate at 2^W-1 and at 0.
- BYPASS, 0, 1 = a register being loaded this cycle shows the load value on o1/o2 in the same cycle.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- funsel  in  2  operation: 00 clear, 01 load, 10 decrement, 11 increment.
- regsel  in  NREG  active-high write mask; bit i enables register i; multiple bits allowed.
- load  in  W  data for the load operation.
- o1sel  in  log2(NREG)  read-port-1 register index.
- o2sel  in  log2(NREG)  read-port-2 register index.
- ovf_clr  in  1  clears all overflow flags.
- o1  out  W  contents of register o1sel.
- o2  out  W  contents of register o2sel.
- ovf  out  NREG  sticky per-register overflow/underflow flags.

Behaviour:
- Reset: on a rising edge with rst=1, all registers become 0 and ovf becomes 0, overriding all other inputs. With no registers written, o1 and o2 read 0 in the cycle after reset.
- Write: on each rising edge, every register i with regsel[i]=1 applies funsel. Registers with regsel[i]=0 hold. regsel=0 is a no-op.
- Clear: the register becomes 0. Its ovf bit is not changed.
- Load: the register takes the value on load, effective in the next cycle (1-cycle latency).
- Increment:
  - From 2^W-1: sets ovf[i]. The result is 0 if SAT=0; the register holds 2^W-1 if SAT=1.
  - Otherwise: value+1.
- Decrement:
  - From 0: sets ovf[i]. The result is 2^W-1 if SAT=0; the register holds 0 if SAT=1.
  - Otherwise: value-1.
- Overflow flags:
  - ovf_clr=1 clears all flags on the edge.
  - If the same edge also sets flag i, the set wins and ovf[i]=1.
  - Flags are otherwise sticky.
- Reads: o1 and o2 are combinational from the register array.
  - Both ports may select the same register.
  - An out-of-range index cannot occur, because NREG is a power of 2.
- Bypass, BYPASS=1: when funsel=01 and regsel[oNsel]=1, oN shows load in the same cycle. Bypass applies to load only; inc/dec/clear are never forwarded.
- Bypass, BYPASS=0: reads always show the registered value.
- Reset mid-operation: rst asserted at any point discards the pending write. State after that edge is all-zero.

Decomposition:
- Package reg_file_pkg:
  - funsel encodings FS_CLR=2'b00, FS_LOAD=2'b01, FS_DEC=2'b10, FS_INC=2'b11.
  - Helper function clog2 for the select width.
- Sub-module reg_cell:
  - One W-bit register plus its ovf bit.
  - Inputs: clk, rst, en, funsel, load, ovf_clr, SAT.
  - Outputs: q, ovf.
  - Instantiated NREG times in a generate loop.
- Top level contains only the generate loop, the two read muxes and the bypass logic.

Test Plan (W=8, NREG=8):
1. rst=1 for one edge after random writes -> all o1/o2 reads 0x00 for every index, ovf=0x00.
2. funsel=01, regsel=8'b0000_0101, load=0x95; next cycle o1sel=0, o2sel=2 -> o1=o2=0x95; register 1 still 0x00.
3. SAT=0: load reg3=0xFF, then increment -> reg3=0x00, ovf=8'b0000_1000. Decrement -> reg3=0xFF; ovf stays set.
4. SAT=1: load reg4=0x00, then decrement -> reg4 stays 0x00, ovf[4]=1. Load 0xFF and increment -> stays 0xFF.
5. ovf_clr=1 on the same edge as an increment of reg5 from 0xFF -> ovf[5]=1, all other flags 0.
6. BYPASS=1: funsel=01, regsel=8'b1000_0000, load=0x3C, o1sel=7 -> o1=0x3C in the same cycle. Repeating with funsel=11 -> o1 shows the old value until the edge.
